// File: rtl/pong_key_decoder.sv
// Turns UART keyboard bytes into Pong controls: held paddle directions,
// a start pulse, a pause toggle, and an unknown-byte pulse.
module pong_key_decoder #(
  parameter int HOLD_CYCLES = 2_500_000,
  parameter int ESC_TIMEOUT = 21_700
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_P1_Up,
  output logic       o_P1_Dn,
  output logic       o_P2_Up,
  output logic       o_P2_Dn,
  output logic       o_Start,
  output logic       o_Pause,
  output logic       o_Unknown
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int EW = $clog2(ESC_TIMEOUT + 1);

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [EW-1:0] ESC_LOAD  = EW'(ESC_TIMEOUT);
  localparam logic [EW-1:0] ESC_ONE   = EW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_e;

  state_e        state_q, state_d;
  logic [EW-1:0] esc_cnt_q, esc_cnt_d;
  logic          start_q, start_d;
  logic          unknown_q, unknown_d;
  logic          pause_q, pause_d;
  logic          idle_decode;

  // Index 0 is player 1, index 1 is player 2.
  dir_e          dir_q  [2];
  dir_e          dir_d  [2];
  dir_e          p_cmd  [2];
  logic [HW-1:0] hold_q [2];
  logic [HW-1:0] hold_d [2];

  // NOTE: every signal gets a default before the case so no path can leave it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    esc_cnt_d   = esc_cnt_q;
    start_d     = 1'b0;
    unknown_d   = 1'b0;
    pause_d     = pause_q;
    idle_decode = 1'b0;
    p_cmd[0]    = DIR_NONE;
    p_cmd[1]    = DIR_NONE;

    case (state_q)
      ST_ESC: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == 8'h5B) begin
            state_d   = ST_CSI;
            esc_cnt_d = ESC_LOAD;
          end else if (i_RX_Byte == 8'h1B) begin
            esc_cnt_d = ESC_LOAD;
          end else begin
            // Not a sequence after all: treat the byte as a plain key.
            state_d     = ST_IDLE;
            esc_cnt_d   = '0;
            idle_decode = 1'b1;
          end
        end else begin
          if (esc_cnt_q != '0) esc_cnt_d = esc_cnt_q - ESC_ONE;
          if (esc_cnt_d == '0) state_d = ST_IDLE;
        end
      end

      ST_CSI: begin
        if (i_RX_DV) begin
          state_d   = ST_IDLE;
          esc_cnt_d = '0;
          case (i_RX_Byte)
            8'h41:   p_cmd[1]  = DIR_UP;
            8'h42:   p_cmd[1]  = DIR_DN;
            default: unknown_d = 1'b1;
          endcase
        end else begin
          if (esc_cnt_q != '0) esc_cnt_d = esc_cnt_q - ESC_ONE;
          if (esc_cnt_d == '0) state_d = ST_IDLE;
        end
      end

      default: idle_decode = i_RX_DV;
    endcase

    if (idle_decode) begin
      case (i_RX_Byte)
        8'h77, 8'h57: p_cmd[0] = DIR_UP;
        8'h73, 8'h53: p_cmd[0] = DIR_DN;
        8'h20:        start_d  = 1'b1;
        8'h70, 8'h50: pause_d  = ~pause_q;
        8'h1B: begin
          state_d   = ST_ESC;
          esc_cnt_d = ESC_LOAD;
        end
        default:      unknown_d = 1'b1;
      endcase
    end
  end

  // A fresh command always wins over expiry, so a key landing on the
  // expiry cycle keeps the paddle moving without a gap.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      dir_d[p]  = dir_q[p];
      hold_d[p] = hold_q[p];
      if (p_cmd[p] != DIR_NONE) begin
        dir_d[p]  = p_cmd[p];
        hold_d[p] = HOLD_LOAD;
      end else if (hold_q[p] != '0) begin
        hold_d[p] = hold_q[p] - HOLD_ONE;
        if (hold_d[p] == '0) dir_d[p] = DIR_NONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      esc_cnt_q <= '0;
      start_q   <= 1'b0;
      unknown_q <= 1'b0;
      pause_q   <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        dir_q[p]  <= DIR_NONE;
        hold_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      esc_cnt_q <= esc_cnt_d;
      start_q   <= start_d;
      unknown_q <= unknown_d;
      pause_q   <= pause_d;
      for (int p = 0; p < 2; p++) begin
        dir_q[p]  <= dir_d[p];
        hold_q[p] <= hold_d[p];
      end
    end
  end

  assign o_P1_Up   = (dir_q[0] == DIR_UP);
  assign o_P1_Dn   = (dir_q[0] == DIR_DN);
  assign o_P2_Up   = (dir_q[1] == DIR_UP);
  assign o_P2_Dn   = (dir_q[1] == DIR_DN);
  assign o_Start   = start_q;
  assign o_Pause   = pause_q;
  assign o_Unknown = unknown_q;

endmodule

// File: tb/tb_pong_key_decoder.sv
// Self-checking bench for pong_key_decoder: a timestamp-based key model is
// compared every cycle, plus hand-computed pulse and hold counts.
module tb_pong_key_decoder;

  localparam int HOLD = 20;
  localparam int ETO  = 10;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       p1_up, p1_dn, p2_up, p2_dn, start, pause, unknown;

  int n_cmp  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  pong_key_decoder #(.HOLD_CYCLES(HOLD), .ESC_TIMEOUT(ETO)) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_l),
    .i_RX_DV   (rx_dv),
    .i_RX_Byte (rx_byte),
    .o_P1_Up   (p1_up),
    .o_P1_Dn   (p1_dn),
    .o_P2_Up   (p2_up),
    .o_P2_Dn   (p2_dn),
    .o_Start   (start),
    .o_Pause   (pause),
    .o_Unknown (unknown)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each player remembers its last command and when it arrived;
  // an escape sequence survives while consecutive bytes are at most ETO edges apart.
  int t = 0;
  int seq, seq_t;
  int pdir [2];
  int pt   [2];
  bit m_pause;
  logic e_p1u, e_p1d, e_p2u, e_p2d, e_start, e_unk;

  task automatic m_clear();
    seq = 0; seq_t = 0; m_pause = 1'b0;
    for (int p = 0; p < 2; p++) begin pdir[p] = 0; pt[p] = -1000000; end
    e_p1u = 0; e_p1d = 0; e_p2u = 0; e_p2d = 0; e_start = 0; e_unk = 0;
  endtask

  task automatic m_cmd(input int p, input int d);
    pdir[p] = d;
    pt[p]   = t;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (seq != 0 && (t - seq_t) > ETO) seq = 0;
    if (seq == 2) begin
      seq = 0;
      if (b == 8'h41) m_cmd(1, 1);
      else if (b == 8'h42) m_cmd(1, 2);
      else e_unk = 1'b1;
      return;
    end
    if (seq == 1) begin
      if (b == 8'h5B) begin seq = 2; seq_t = t; return; end
      if (b == 8'h1B) begin seq_t = t; return; end
      seq = 0;
    end
    case (b)
      8'h77, 8'h57: m_cmd(0, 1);
      8'h73, 8'h53: m_cmd(0, 2);
      8'h20:        e_start = 1'b1;
      8'h70, 8'h50: m_pause = ~m_pause;
      8'h1B:        begin seq = 1; seq_t = t; end
      default:      e_unk = 1'b1;
    endcase
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_l);
      if (!rst_l) m_clear();
      else begin
        t++;
        e_start = 1'b0;
        e_unk   = 1'b0;
        if (rx_dv) m_byte(rx_byte);
        e_p1u = (pdir[0] == 1) && (t - pt[0] < HOLD);
        e_p1d = (pdir[0] == 2) && (t - pt[0] < HOLD);
        e_p2u = (pdir[1] == 1) && (t - pt[1] < HOLD);
        e_p2d = (pdir[1] == 2) && (t - pt[1] < HOLD);
      end
    end
  end

  initial begin
    wait (armed);
    forever begin
      @(negedge clk);
      check("p1_up",   p1_up,   e_p1u);
      check("p1_dn",   p1_dn,   e_p1d);
      check("p2_up",   p2_up,   e_p2u);
      check("p2_dn",   p2_dn,   e_p2d);
      check("start",   start,   e_start);
      check("pause",   pause,   m_pause);
      check("unknown", unknown, e_unk);
    end
  end

  // Stimulus helpers: every task starts and ends 1 time unit after a rising edge.
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    sync();
    rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  int c_p1u, c_p1d, c_p2u, c_p2d, c_st, c_unk;

  task automatic watch(input int n);
    c_p1u = 0; c_p1d = 0; c_p2u = 0; c_p2d = 0; c_st = 0; c_unk = 0;
    repeat (n) begin
      @(negedge clk);
      c_p1u += int'(p1_up); c_p1d += int'(p1_dn);
      c_p2u += int'(p2_up); c_p2d += int'(p2_dn);
      c_st  += int'(start); c_unk += int'(unknown);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_p1_up"}, p1_up, 0);
    check({tag, "_p1_dn"}, p1_dn, 0);
    check({tag, "_p2_up"}, p2_up, 0);
    check({tag, "_p2_dn"}, p2_dn, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_pause"}, pause, 0);
    check({tag, "_unk"},   unknown, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_l = 1'b1;
    sync();
    armed = 1'b1;
    all_zero("reset");

    // Single key: exactly HOLD cycles of P1 up.
    fork watch(40); send(8'h77); join
    check("hold_single", c_p1u, 20);
    sync(); idle(30);

    // Repeat at cycle 15 extends the hold to cycle 35.
    fork watch(50); begin send(8'h77); idle(14); send(8'h77); end join
    check("hold_repeat", c_p1u, 35);
    sync(); idle(30);

    // Direction switch 5 cycles later.
    fork watch(40); begin send(8'h77); idle(4); send(8'h73); end join
    check("switch_up", c_p1u, 5);
    check("switch_dn", c_p1d, 20);
    sync(); idle(30);

    // Arrow up, then an unsupported arrow.
    fork watch(40); begin send(8'h1B); send(8'h5B); send(8'h41); end join
    check("arrow_up", c_p2u, 20);
    check("arrow_up_unk", c_unk, 0);
    sync(); idle(30);
    fork watch(30); begin send(8'h1B); send(8'h5B); send(8'h43); end join
    check("arrow_c_unk", c_unk, 1);
    check("arrow_c_p2", c_p2u + c_p2d, 0);
    sync(); idle(30);

    // ESC timeout: the late 'A' is an ordinary unknown byte.
    fork watch(50); begin send(8'h1B); idle(12); send(8'h41); end join
    check("esc_to_p2u", c_p2u, 0);
    check("esc_to_unk", c_unk, 1);
    sync(); idle(30);

    // ESC followed by a plain key decodes that key.
    fork watch(40); begin send(8'h1B); send(8'h53); end join
    check("esc_S_p1dn", c_p1d, 20);
    check("esc_S_unk", c_unk, 0);
    sync(); idle(30);

    // Doubled ESC keeps the sequence alive.
    fork watch(40); begin send(8'h1B); send(8'h1B); idle(3); send(8'h5B); send(8'h41); end join
    check("esc_esc_p2u", c_p2u, 20);
    sync(); idle(30);

    // Start pulse and back-to-back unknowns.
    fork watch(10); send(8'h20); join
    check("start_pulse", c_st, 1);
    sync();
    fork watch(10); begin send(8'h78); send(8'h79); end join
    check("unk_b2b", c_unk, 2);
    sync(); idle(5);

    // Pause toggling.
    send(8'h70); #4 check("pause_p", pause, 1);
    sync(); send(8'h50); #4 check("pause_P", pause, 0);
    sync(); send(8'h70); #4 check("pause_p2", pause, 1);
    sync(); idle(5);

    // Players held independently.
    fork watch(40); begin send(8'h77); idle(3); send(8'h1B); send(8'h5B); send(8'h42); end join
    check("indep_p1u", c_p1u, 20);
    check("indep_p2d", c_p2d, 20);
    sync(); idle(30);

    // Reset mid-hold and mid-CSI, with pause still set.
    send(8'h77); idle(5); send(8'h1B); send(8'h5B);
    #3 rst_l = 1'b0;
    #1 all_zero("midrst");
    idle(3);
    #2 rst_l = 1'b1;
    sync();
    fork watch(30); send(8'h41); join
    check("post_rst_unk", c_unk, 1);
    check("post_rst_p2u", c_p2u, 0);
    sync(); idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_key_decoder.md
# pong_key_decoder

Consumes the byte stream from the UART receiver (one-cycle valid strobe plus byte) and turns keyboard traffic from a terminal into Pong control signals. Paddle direction levels are held for a programmable time after each keypress, which bridges terminal key-repeat gaps. It also emits a game-start pulse and a pause toggle. It sits between the UART receiver and the paddle/game-control logic.

## Interface
- HOLD_CYCLES, 2_500_000 — cycles a paddle direction stays asserted after its last key (100 ms at 25 MHz)
- ESC_TIMEOUT, 21_700 — max cycles allowed between bytes of an escape sequence (about 10 byte times at 115200 baud)
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  asynchronous, active-low reset
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte valid
- i_RX_Byte  in  8  received byte
- o_P1_Up / o_P1_Dn  out  1  paddle 1 move levels
- o_P2_Up / o_P2_Dn  out  1  paddle 2 move levels
- o_Start  out  1  one-cycle start pulse
- o_Pause  out  1  pause level, toggled by key
- o_Unknown  out  1  one-cycle pulse on an unrecognised or discarded byte

## Operation
**Key map, decoded only in IDLE:**
- 0x77/0x57 'w'/'W' → P1 up.
- 0x73/0x53 's'/'S' → P1 down.
- 0x20 space → o_Start pulse.
- 0x70/0x50 'p'/'P' → toggle o_Pause.
- 0x1B ESC → go to ESC.
- Any other byte → o_Unknown pulse.

**Parser FSM (IDLE, ESC, CSI):**
- ESC + 0x5B '[' → CSI.
- ESC + 0x1B → stay in ESC; reload timeout.
- ESC + any other byte → return to IDLE and decode that same byte as an IDLE byte in the same cycle (ESC then 'w' gives P1 up).
- CSI + 0x41 'A' → P2 up, then IDLE.
- CSI + 0x42 'B' → P2 down, then IDLE.
- CSI + any other byte → o_Unknown pulse, then IDLE.
- ESC/CSI timeout: a down-counter loads ESC_TIMEOUT on entry to ESC or CSI. When it reaches 0 with no byte received, the state returns to IDLE. A timeout does not pulse o_Unknown.

**Per-player hold:**
- Each player has a direction register (NONE/UP/DN) and a hold counter sized by $clog2(HOLD_CYCLES+1).
- A command for a player sets that player's direction and loads HOLD_CYCLES. The opposite direction clears immediately.
- The counter decrements every cycle while nonzero. Direction becomes NONE in the cycle the counter reaches 0.
- Up and Dn of the same player are never both 1.
- Players are independent: a P1 command never affects P2's hold.

## Timing
- Reset: all outputs 0, FSM in IDLE, all counters 0, direction NONE.
- Reset is asynchronous and may occur mid-sequence or mid-hold; it returns everything to the reset state.
- Latency: a byte with i_RX_DV high at edge N affects outputs after edge N+1. All outputs are registered.
- o_Start and o_Unknown are exactly one cycle wide per triggering byte.
- Hold duration: a single key gives a direction high for exactly HOLD_CYCLES cycles.
- Repeat key before expiry: the counter reloads and the output stays high with no gap.
- i_RX_DV in the same cycle a hold counter expires: the new command wins; the output stays high or switches.
- i_RX_DV in the same cycle the ESC/CSI timeout expires: the byte is processed in the current state and the timeout is ignored.
- i_RX_DV is at most one per byte time. Back-to-back DV on consecutive cycles must still be handled, one byte per cycle.
- Bytes while paused are decoded normally; pausing is the consumer's responsibility.

## Test plan
Bench parameters: HOLD_CYCLES=20, ESC_TIMEOUT=10.
- **Reset:** assert i_Rst_L=0 mid-hold (P1 up active) and mid-CSI → all outputs 0 immediately. After release, 0x41 alone produces o_Unknown and no P2 up.
- **Hold:** 'w' at cycle 0 → o_P1_Up high for cycles 1..20, low at 21. Resending 'w' at cycle 15 → high continuously until cycle 35.
- **Direction switch:** 'w' then 's' 5 cycles later → o_P1_Up falls and o_P1_Dn rises on the same edge; never both high.
- **Arrows:** 0x1B,0x5B,0x41 → o_P2_Up for 20 cycles. 0x1B,0x5B,0x43 → one o_Unknown pulse, no P2 change.
- **ESC handling:**
  - 0x1B then idle 12 cycles then 0x41 → no P2 up; one o_Unknown for 0x41.
  - 0x1B then 'S' → o_P1_Dn asserted.
- **Misc keys:**
  - 0x20 → single-cycle o_Start.
  - 'p','P' → o_Pause goes 1 then 0.
  - 'w' and 0x1B,0x5B,0x42 interleaved → P1 up and P2 down held independently.
